// File: rtl/vga_pixel_pipe.sv
// Pixel stage behind the VGA timing controller: framebuffer fetch, palette lookup,
// 8x8 cursor overlay and sync delay, all aligned to a 3-cycle pipeline.
module vga_pixel_pipe #(
    parameter logic [9:0]  HACTIVE   = 10'd640,
    parameter logic [9:0]  VACTIVE   = 10'd480,
    parameter int          ADDR_W    = 15,
    parameter logic [10:0] CURSOR_SZ = 11'd8
) (
    input  logic              vgaclk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [3:0]        fb_rdata,
    input  logic              pal_we,
    input  logic [3:0]        pal_waddr,
    input  logic [11:0]       pal_wdata,
    input  logic              cursor_en,
    input  logic [9:0]        cursor_x,
    input  logic [9:0]        cursor_y,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        r,
    output logic [3:0]        g,
    output logic [3:0]        b,
    output logic              frame_start
);

    logic              in_active;
    logic              in_hit;
    logic              in_first;
    logic              shadow_load;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] addr_calc;
    logic [10:0]       x_w, y_w, cx_w, cy_w;

    logic              cur_en_s;
    logic [9:0]        cur_x_s, cur_y_s;

    logic              s1_active, s1_hit, s1_hs, s1_vs, s1_first;
    logic              s2_active, s2_hit, s2_hs, s2_vs, s2_first;
    logic [11:0]       rgb_q;
    logic [11:0]       palette [16];

    assign in_active   = (x < HACTIVE) && (y < VACTIVE);
    assign in_first    = (x == 10'd0) && (y == 10'd0);
    assign shadow_load = (x == 10'd0) && (y == VACTIVE);

    // Row * 160 as (row*128 + row*32); only meaningful inside the visible area.
    assign row       = ADDR_W'(y[9:2]);
    assign addr_calc = (row << 7) + (row << 5) + ADDR_W'(x[9:2]);

    // 11-bit compare so a cursor near x/y = 1023 cannot wrap back onto column/row 0.
    assign x_w    = {1'b0, x};
    assign y_w    = {1'b0, y};
    assign cx_w   = {1'b0, cur_x_s};
    assign cy_w   = {1'b0, cur_y_s};
    assign in_hit = cur_en_s
                  && (x_w >= cx_w) && (x_w < cx_w + CURSOR_SZ)
                  && (y_w >= cy_w) && (y_w < cy_w + CURSOR_SZ);

    // Cursor settings are sampled once per frame at the start of vertical blank.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            cur_en_s <= 1'b0;
            cur_x_s  <= 10'd0;
            cur_y_s  <= 10'd0;
        end else if (shadow_load) begin
            cur_en_s <= cursor_en;
            cur_x_s  <= cursor_x;
            cur_y_s  <= cursor_y;
        end
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            fb_addr   <= '0;
            s1_active <= 1'b0;
            s1_hit    <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_first  <= 1'b0;
            s2_active <= 1'b0;
            s2_hit    <= 1'b0;
            s2_hs     <= 1'b1;
            s2_vs     <= 1'b1;
            s2_first  <= 1'b0;
        end else begin
            fb_addr   <= in_active ? addr_calc : '0;
            s1_active <= in_active;
            s1_hit    <= in_hit;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
            s1_first  <= in_first;
            s2_active <= s1_active;
            s2_hit    <= s1_hit;
            s2_hs     <= s1_hs;
            s2_vs     <= s1_vs;
            s2_first  <= s1_first;
        end
    end

    // A lookup on the same edge as a write to that entry sees the old colour.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= {3{4'(i)}};
            end
        end else if (pal_we) begin
            palette[pal_waddr] <= pal_wdata;
        end
    end

    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            rgb_q       <= 12'h000;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            if (!s2_active) begin
                rgb_q <= 12'h000;
            end else if (s2_hit) begin
                rgb_q <= 12'hFFF;
            end else begin
                rgb_q <= palette[fb_rdata];
            end
            hsync       <= s2_hs;
            vsync       <= s2_vs;
            frame_start <= s2_first;
        end
    end

    assign r = rgb_q[11:8];
    assign g = rgb_q[7:4];
    assign b = rgb_q[3:0];

endmodule

// File: doc/vga_pixel_pipe.md
# vga_pixel_pipe

Pixel-generation stage directly downstream of the VGA timing controller. It consumes the controller's raw x/y counters and active-low syncs. It fetches 4-bit palette indices from a 160×120 framebuffer in external synchronous RAM, with each framebuffer pixel covering a 4×4 screen block. It maps each index through a 16-entry writable palette, overlays an 8×8 hardware cursor, and drives 12-bit RGB plus syncs delayed so that every output stays pixel-aligned.

## Interface
- HACTIVE, 10'd640, visible pixels per line
- VACTIVE, 10'd480, visible lines per frame
- FB_W, 160, framebuffer width in pixels (screen x >> 2)
- ADDR_W, 15, framebuffer address width (19200 entries)
- CURSOR_SZ, 11'd8, cursor box edge length in screen pixels

- vgaclk  input  1  pixel clock
- reset  input  1  asynchronous, active-high reset
- x  input  10  horizontal counter from timing controller
- y  input  10  vertical counter from timing controller
- hsync_in  input  1  active-low hsync from controller
- vsync_in  input  1  active-low vsync from controller
- fb_addr  output  ADDR_W  framebuffer read address (registered)
- fb_rdata  input  4  palette index returned by RAM one cycle after fb_addr
- pal_we  input  1  palette write strobe
- pal_waddr  input  4  palette entry to write
- pal_wdata  input  12  {R[3:0],G[3:0],B[3:0]}
- cursor_en  input  1  cursor enable (shadowed)
- cursor_x  input  10  cursor left edge, screen pixels (shadowed)
- cursor_y  input  10  cursor top edge, screen pixels (shadowed)
- hsync  output  1  delayed hsync_in
- vsync  output  1  delayed vsync_in
- r, g, b  output  4 each  pixel colour
- frame_start  output  1  one-cycle pulse aligned with the RGB of pixel (0,0)

## Operation
- Stage 1 (edge after x/y is presented):
  - Registers active = (x < HACTIVE) & (y < VACTIVE).
  - Registers fb_addr = (y>>2)*FB_W + (x>>2), computed as ((y>>2)<<7) + ((y>>2)<<5) + (x>>2). Width is ADDR_W with no overflow, because the maximum address is 19199.
  - When not active, fb_addr is forced to 0.
  - Registers the cursor hit, computed in 11 bits so it never wraps: cursor_en_s & (x >= cx) & (x < cx+CURSOR_SZ) & (y >= cy) & (y < cy+CURSOR_SZ).
  - Registers the syncs and first_pix = (x==0 & y==0).
- Stage 2: the RAM presents fb_rdata. The active, hit, sync and first_pix flags advance one register.
- Stage 3, output register:
  - If not active: rgb = 0.
  - Else if hit: rgb = 12'hFFF.
  - Otherwise: rgb = palette[fb_rdata].
  - hsync, vsync and frame_start are driven from the stage-3 registers.
- Palette: 16×12 register file.
  - The write on the pal_we edge is visible to lookups from the next cycle onward.
  - If a write and a lookup hit the same entry on the same edge, the lookup returns the old value.
  - Reset value of entry i is {i,i,i} (grayscale ramp).
- Cursor shadow registers:
  - Loaded from cursor_en/x/y on the cycle where x==0 & y==VACTIVE (start of vertical blank).
  - Held constant for the whole visible frame, so mid-frame changes take effect next frame.
- Counters outside the visible area, including x up to the controller's maximum count, are only blanked. The block does not depend on the controller's wrap value.
- Clipping at the screen edge: cursor_x=636 draws columns 636..639 only; cursor_x ≥ 640 draws nothing.

## Timing
- Latency is 3 vgaclk cycles from x/y/hsync_in/vsync_in to r/g/b/hsync/vsync/frame_start.
- fb_addr is valid 1 cycle after x/y.
- The RAM must have exactly 1-cycle read latency.
- Reset values (asynchronous, immediate):
  - All pipeline flags 0.
  - fb_addr = 0, r/g/b = 0, frame_start = 0.
  - hsync = vsync = 1 (inactive), including the internal sync delay registers.
  - Cursor shadow = disabled, position 0.
  - Palette = grayscale ramp.
- Reset mid-frame: outputs take their reset values at once. After release, the first 3 output cycles show reset contents (syncs high, black), then track the inputs.
- frame_start pulses high for exactly 1 cycle per frame.

## Test plan
- Reset release with x=0,y=0 driven: 3 cycles of rgb=0 and hsync=vsync=1, then frame_start=1 on cycle 3 with rgb=palette[fb_rdata].
- Address map: x=7,y=5 → fb_addr=161 one cycle later. x=639,y=479 → fb_addr=19199. x=640,y=10 → fb_addr=0 and rgb=0 three cycles later.
- Palette: write entry 3 = 12'hA5C, return fb_rdata=3 → rgb=A,5,C. Write and lookup of entry 3 on the same edge → old value output.
- Cursor: cursor_en=1, (100,50) latched at y=480,x=0 → pixels x 100..107, y 50..57 read FFF next frame. Moving the cursor mid-frame leaves the current frame unchanged.
- Sync alignment: an hsync_in low pulse starting at x=656 → hsync low starting 3 cycles later for the same pulse width. A vsync_in edge is delayed likewise.
